// File: rtl/keypad_scan_ctrl_if.sv
// Signal bundle between the keypad scan controller and the keypad row decoder /
// column encoder plus the key consumers.
interface keypad_scan_ctrl_if;
    logic [1:0] row_sel;
    logic [1:0] col_code;
    logic       col_hit;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_sel,
        output key_code,
        output key_valid,
        output key_held,
        input  col_code,
        input  col_hit
    );

    modport slave (
        input  row_sel,
        input  key_code,
        input  key_valid,
        input  key_held,
        output col_code,
        output col_hit
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Row-stepping scan controller for a 4x4 keypad: samples the column encoder once
// per row dwell, debounces press and release, and reports each accepted key once.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_scan_ctrl_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_SCAN = 2'd0,
        S_DEB  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    row;
    logic [3:0]    cand;
    logic [3:0]    code;
    logic          valid;
    logic          held;
    logic          sample;
    logic          cand_match;

    // Inputs are only trusted at the end of a dwell, after the row has settled.
    assign sample     = (dwell == DWELL_LAST);
    assign cnt_inc    = cnt + 1'b1;
    assign cand_match = kp.col_hit && (kp.col_code == cand[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_SCAN;
            dwell <= '0;
            cnt   <= '0;
            row   <= 2'd0;
            code  <= 4'd0;
            valid <= 1'b0;
            held  <= 1'b0;
        end else begin
            valid <= 1'b0;
            dwell <= sample ? '0 : dwell + 1'b1;
            if (sample) begin
                case (state)
                    S_SCAN: begin
                        if (!kp.col_hit) begin
                            row <= row + 1'b1;
                        end else if (DEBOUNCE == 1) begin
                            code  <= {row, kp.col_code};
                            valid <= 1'b1;
                            held  <= 1'b1;
                            cnt   <= '0;
                            state <= S_HOLD;
                        end else begin
                            cnt   <= CNT_ONE;
                            state <= S_DEB;
                        end
                    end
                    S_DEB: begin
                        if (cand_match) begin
                            if (cnt_inc == CNT_DONE) begin
                                code  <= cand;
                                valid <= 1'b1;
                                held  <= 1'b1;
                                cnt   <= '0;
                                state <= S_HOLD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // Bounce or column change: drop the candidate silently.
                            cnt   <= '0;
                            row   <= row + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                    S_HOLD: begin
                        // Any hit in the frozen row keeps the key held and restarts release.
                        if (kp.col_hit) begin
                            cnt <= '0;
                        end else if (cnt_inc == CNT_DONE) begin
                            cnt   <= '0;
                            held  <= 1'b0;
                            row   <= row + 1'b1;
                            state <= S_SCAN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= S_SCAN;
                    end
                endcase
            end
        end
    end

    // Candidate key is pure data; it is only read after being written in SCAN.
    always_ff @(posedge clk) begin
        if (sample && state == S_SCAN && kp.col_hit) begin
            cand <= {row, kp.col_code};
        end
    end

    assign kp.row_sel   = row;
    assign kp.key_code  = code;
    assign kp.key_valid = valid;
    assign kp.key_held  = held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE=3 and a
// behavioural keypad that answers the driven row with a priority column code.
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  rowbits;
    int          edge_n;
    int          vld_seen;
    int          checks;
    int          failures;

    keypad_scan_ctrl_if kp();

    keypad_scan_ctrl #(
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: lowest pressed column in the driven row wins.
    always_comb begin
        rowbits     = keys[{kp.row_sel, 2'b00} +: 4];
        kp.col_hit  = |rowbits;
        kp.col_code = 2'd0;
        if (rowbits[0])      kp.col_code = 2'd0;
        else if (rowbits[1]) kp.col_code = 2'd1;
        else if (rowbits[2]) kp.col_code = 2'd2;
        else if (rowbits[3]) kp.col_code = 2'd3;
    end

    typedef struct {
        bit          rst;
        string       name;
        int          at;
        logic [15:0] keys;
        logic [1:0]  row;
        logic [3:0]  code;
        logic        vld;
        logic        held;
    } vec_t;

    vec_t tab[$];

    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K7  = 16'h0080;
    localparam logic [15:0] K10 = 16'h0400;

    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (kp.key_valid === 1'b1) vld_seen++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        edge_n   = -1;
        vld_seen = 0;
    endtask

    task automatic check(input string name, input logic [1:0] er, input logic [3:0] ec,
                         input logic ev, input logic eh);
        checks++;
        if (kp.row_sel !== er || kp.key_code !== ec || kp.key_valid !== ev || kp.key_held !== eh) begin
            failures++;
            $display("FAIL %s edge=%0d got row=%0d code=%h valid=%b held=%b expected row=%0d code=%h valid=%b held=%b",
                     name, edge_n, kp.row_sel, kp.key_code, kp.key_valid, kp.key_held, er, ec, ev, eh);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        keys     = 16'h0000;
        rst_n    = 1'b0;
        edge_n   = -1;
        vld_seen = 0;

        // Idle scan
        tab.push_back('{1'b1, "idle_e2",  2,  16'h0000, 2'd0, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "idle_e3",  3,  16'h0000, 2'd1, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "idle_e7",  7,  16'h0000, 2'd2, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "idle_e11", 11, 16'h0000, 2'd3, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "idle_e14", 14, 16'h0000, 2'd3, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "idle_e15", 15, 16'h0000, 2'd0, 4'h0, 1'b0, 1'b0});
        // Clean press of row 2 col 1 held from cycle 0
        tab.push_back('{1'b1, "press_e10", 10, K9, 2'd2, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "press_e11", 11, K9, 2'd2, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "press_e15", 15, K9, 2'd2, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "press_e18", 18, K9, 2'd2, 4'h0, 1'b0, 1'b0});
        tab.push_back('{1'b0, "press_e19", 19, K9, 2'd2, 4'h9, 1'b1, 1'b1});
        tab.push_back('{1'b0, "press_e20", 20, K9, 2'd2, 4'h9, 1'b0, 1'b1});
        // Release with a glitch hit at the second miss sample (edge 27)
        tab.push_back('{1'b0, "rel_e23",    23, 16'h0000, 2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_e26",    26, 16'h0000, 2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_glitch", 27, K9,       2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_e31",    31, 16'h0000, 2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_e35",    35, 16'h0000, 2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_e38",    38, 16'h0000, 2'd2, 4'h9, 1'b0, 1'b1});
        tab.push_back('{1'b0, "rel_e39",    39, 16'h0000, 2'd3, 4'h9, 1'b0, 1'b0});

        foreach (tab[i]) begin
            if (tab[i].rst) do_reset();
            keys = tab[i].keys;
            run_to(tab[i].at);
            check(tab[i].name, tab[i].row, tab[i].code, tab[i].vld, tab[i].held);
        end
        check_int("press_release_strobes", vld_seen, 1);

        // Bounce: row 1 col 3 seen at sample 7 only
        do_reset();
        keys = K7;
        run_to(7);
        keys = 16'h0000;
        run_to(10);
        check("bounce_frozen", 2'd1, 4'h0, 1'b0, 1'b0);
        run_to(11);
        check("bounce_drop", 2'd2, 4'h0, 1'b0, 1'b0);
        run_to(30);
        check("bounce_e30", 2'd2, 4'h0, 1'b0, 1'b0);
        check_int("bounce_strobes", vld_seen, 0);

        // Column change during debounce
        do_reset();
        keys = K9;
        run_to(11);
        check("colchg_cand", 2'd2, 4'h0, 1'b0, 1'b0);
        keys = K10;
        run_to(15);
        keys = 16'h0000;
        check("colchg_drop", 2'd3, 4'h0, 1'b0, 1'b0);
        run_to(24);
        check_int("colchg_strobes", vld_seen, 0);

        // Reset in the middle of HOLD with the key still pressed
        do_reset();
        check("reset_state", 2'd0, 4'h0, 1'b0, 1'b0);
        keys = K9;
        run_to(20);
        check("hold_before_rst", 2'd2, 4'h9, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_hold", 2'd0, 4'h0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        edge_n   = -1;
        vld_seen = 0;
        run_to(18);
        check_int("rst_no_early_strobe", vld_seen, 0);
        check("rst_e18", 2'd2, 4'h0, 1'b0, 1'b0);
        run_to(19);
        check("rst_redetect", 2'd2, 4'h9, 1'b1, 1'b1);
        run_to(20);
        check("rst_redetect_end", 2'd2, 4'h9, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequential scan controller for the calculator's 4x4 matrix keypad. It steps the 2-bit row-select code into the row decoder, samples the column encoder's code and hit flag, and debounces the result. On a press it emits one registered 4-bit key code with a single-cycle valid strobe, which the key-to-BCD path and the calculator core consume.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven (dwell). Legal range ≥ 2.
- `DEBOUNCE`, default 4: consecutive matching samples needed to accept a press and also to accept a release. Legal range ≥ 1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `row_sel` out 2: row index to the row decoder (0 drives row 0 … 3 drives row 3).
- `col_code` in 2: column index from the column encoder.
- `col_hit` in 1: encoder output-enable; 1 means some column in the driven row is active.
- `key_code` out 4: last accepted key, {row, col} = row*4 + col.
- `key_valid` out 1: one-cycle pulse when `key_code` updates.
- `key_held` out 1: 1 while the accepted key is still pressed.

## Operation
- Dwell counter `dwell` counts 0..SCAN_DIV-1 and wraps. Its width is $clog2(SCAN_DIV).
- Sampling happens only on the edge where `dwell == SCAN_DIV-1`, which gives maximum settling time. `col_hit` and `col_code` are ignored on all other cycles.
- FSM states and transitions:
  - SCAN: at each sample, if `col_hit` = 0, `row_sel` advances (3 wraps to 0). If `col_hit` = 1, latch cand = {row_sel, col_code}, set match count = 1, freeze `row_sel`, and go to DEBOUNCE. When DEBOUNCE = 1, go straight to HOLD and accept instead.
  - DEBOUNCE: `row_sel` stays frozen.
    - At a sample with `col_hit` = 1 and `col_code` == cand[1:0], increment the count. When it reaches DEBOUNCE, `key_code` ← cand, pulse `key_valid`, go to HOLD.
    - At a sample with `col_hit` = 0 or a different `col_code`, discard cand, advance `row_sel`, return to SCAN. No strobe is produced.
  - HOLD: `row_sel` stays frozen and `key_held` = 1.
    - At a sample with `col_hit` = 1 (any column), the release count resets to 0.
    - At a sample with `col_hit` = 0, increment the release count. At DEBOUNCE, clear `key_held`, advance `row_sel`, and go to SCAN.
- Multiple keys:
  - Within one row, the encoder's priority decides (lowest column wins).
  - Keys in other rows are invisible while frozen in DEBOUNCE or HOLD.
  - A second key in the same row during HOLD neither generates a new code nor ends HOLD.
- `key_code` holds its value until the next accepted press. No auto-repeat.
- Reset values:
  - state = SCAN, `dwell` = 0, counts = 0.
  - `row_sel` = 0, `key_code` = 0, `key_valid` = 0, `key_held` = 0.
- Reset has priority over every other event.
  - Reset during DEBOUNCE or HOLD clears everything with no `key_valid` pulse.
  - After reset, a key still pressed is re-detected from SCAN as a new press.

## Timing
- All outputs are registered. `row_sel` changes on the sample edge, so the new row is driven for the full next dwell.
- `key_valid` is high for exactly the one cycle after the sample edge that completes debounce. `key_code` and `key_held` change on that same edge.
- Press latency: from the first hit sample to `key_valid` is (DEBOUNCE-1)*SCAN_DIV + 1 cycles.
- Release latency: from the first miss sample to `key_held` falling is (DEBOUNCE-1)*SCAN_DIV + 1 cycles.
- Full scan period while idle: 4*SCAN_DIV cycles.
- Cycle numbering: cycle 0 is the first edge with `rst_n` = 1.

## Test plan
All scenarios use bench parameters SCAN_DIV = 4, DEBOUNCE = 3.
- Idle scan: no key pressed.
  - `row_sel` steps 0→1→2→3→0, changing after cycles 3, 7, 11, 15.
  - `key_valid` and `key_held` stay 0.
- Clean press, row 2 col 1 held from cycle 0:
  - First hit sample at cycle 11; `row_sel` stays 2.
  - `key_valid` = 1 only in cycle 20, with `key_code` = 0x9 and `key_held` = 1.
- Bounce: key row 1 col 3 present at the cycle-7 sample, absent at the cycle-11 sample.
  - No `key_valid`; `row_sel` advances to 2 after cycle 11.
  - `key_code` stays 0.
- Release debounce: from HOLD with key 0x9, key removed, then one glitch hit at the second miss sample.
  - Release count restarts at the glitch.
  - `key_held` falls only after 3 consecutive misses; `row_sel` then becomes 3.
- Column change during DEBOUNCE: cand col 1, next sample reports col 2 in the same row.
  - Return to SCAN with no strobe.
- Reset mid-HOLD: pulse `rst_n` low for one cycle with the key still pressed.
  - All outputs go to 0 the next cycle.
  - Key 0x9 is re-reported with a fresh `key_valid` 20 cycles after reset release.
